// File: rtl/div_4.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// started by a rising edge on init, completion signalled by a one-cycle done.
module div_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           r_init_q;
    logic           w_start;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   w_rem_s;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_dvd_next;
    logic             w_last;

    assign w_start = init & ~r_init_q;
    assign w_last  = (r_cnt == CW'(1));

    // The stored partial remainder is always below 2^WIDTH, so only the
    // shifted value needs the extra bit for the trial subtraction.
    assign w_rem_s    = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial    = w_rem_s - {1'b0, r_dvs};
    assign w_ge       = ~w_trial[WIDTH];
    assign w_rem_next = w_ge ? w_trial[WIDTH-1:0] : w_rem_s[WIDTH-1:0];
    assign w_dvd_next = {r_dvd[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_ITER;
            S_ITER:  if (w_last)  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_q    <= 1'b0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            r_init_q <= init;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_dvd <= A;
                        r_dvs <= B;
                        r_rem <= '0;
                        r_cnt <= CW'(WIDTH);
                    end
                end
                S_ITER: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_dvd_next;
                    r_cnt <= r_cnt - CW'(1);
                    // Results are captured from the final iteration's next
                    // values so they appear on entry into DONE.
                    if (w_last) begin
                        quotient    <= w_dvd_next;
                        remainder   <= w_rem_next;
                        div_by_zero <= (r_dvs == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_ITER);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_div_4.sv
// Directed self-checking bench for div_4: handshake timing, results,
// divide-by-zero, reset abort, ignored restarts and a full operand sweep.
module tb_div_4;
    logic       clk;
    logic       rst;
    logic       init;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    div_4 #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .init        (init),
        .A           (A),
        .B           (B),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one operation and checks busy/done timing cycle by cycle.
    // hold keeps init high across a second edge; reinit raises init again
    // mid-operation and scrambles the operands.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input bit hold, input bit reinit,
                          input logic [3:0] eq, input logic [3:0] er, input logic edz);
        @(negedge clk);
        A = a;
        B = b;
        init = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) init = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        check("done_after_start", {31'b0, done}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) init = 1'b0;
            if (reinit && i == 2) begin
                init = 1'b1;
                A = 4'd15;
                B = 4'd1;
            end
            if (reinit && i == 3) init = 1'b0;
            if (i < 4) begin
                check("busy_iter", {31'b0, busy}, 32'd1);
                check("done_iter", {31'b0, done}, 32'd0);
            end else if (i == 4) begin
                check("done_high", {31'b0, done}, 32'd1);
                check("busy_in_done", {31'b0, busy}, 32'd0);
                check("quotient", {28'b0, quotient}, {28'b0, eq});
                check("remainder", {28'b0, remainder}, {28'b0, er});
                check("div_by_zero", {31'b0, div_by_zero}, {31'b0, edz});
            end else begin
                check("done_fall", {31'b0, done}, 32'd0);
                check("busy_idle", {31'b0, busy}, 32'd0);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        init = 1'b0;
        A    = '0;
        B    = '0;
        #1;
        check("rst_quotient", {28'b0, quotient}, 32'd0);
        check("rst_remainder", {28'b0, remainder}, 32'd0);
        check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 10/3
        run_op(4'd10, 4'd3, 1'b0, 1'b0, 4'd3, 4'd1, 1'b0);

        // 10/10 with init held two cycles: exactly one operation
        run_op(4'd10, 4'd10, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("no_second_op_busy", {31'b0, busy}, 32'd0);
            check("no_second_op_done", {31'b0, done}, 32'd0);
        end

        run_op(4'd15, 4'd1, 1'b0, 1'b0, 4'd15, 4'd0, 1'b0);
        run_op(4'd3, 4'd9, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0);
        run_op(4'd7, 4'd0, 1'b0, 1'b0, 4'd15, 4'd7, 1'b1);
        run_op(4'd6, 4'd2, 1'b0, 1'b0, 4'd3, 4'd0, 1'b0);

        // Reset during the second ITER cycle of 13/4
        @(negedge clk);
        A = 4'd13;
        B = 4'd4;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        @(posedge clk);
        #2;
        check("pre_abort_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_quotient", {28'b0, quotient}, 32'd0);
        check("abort_remainder", {28'b0, remainder}, 32'd0);
        check("abort_dbz", {31'b0, div_by_zero}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", {31'b0, done}, 32'd0);
        end
        run_op(4'd13, 4'd4, 1'b0, 1'b0, 4'd3, 4'd1, 1'b0);

        // Restart edge during ITER of 9/2 is ignored
        run_op(4'd9, 4'd2, 1'b0, 1'b1, 4'd4, 4'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("ignored_restart_idle", {31'b0, busy}, 32'd0);
        end

        // Full sweep of every operand pair
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0] eq;
                logic [3:0] er;
                eq = (b == 0) ? 4'hF : 4'(a / b);
                er = (b == 0) ? 4'(a) : 4'(a % b);
                run_op(4'(a), 4'(b), 1'b0, 1'b0, eq, er, (b == 0));
                if (b != 0) begin
                    check("identity", {28'b0, quotient} * 32'(b) + {28'b0, remainder}, 32'(a));
                    check("rem_lt_b", {31'b0, (32'(remainder) < 32'(b))}, 32'd1);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
